// File: rtl/arp_lookup_cache_pkg.sv
// Shared constants, reply layout and FSM encoding for the ARP lookup cache.
package arp_lookup_cache_pkg;

  localparam int ARP_LUP_REQ_BITS = 32;
  localparam int ARP_LUP_RSP_BITS = 56;
  localparam int MAC_ADDR_BITS    = 48;
  localparam int ARP_RSP_HIT_BIT  = 48;

  typedef struct packed {
    logic [6:0]               rsvd;
    logic                     hit;
    logic [MAC_ADDR_BITS-1:0] mac;
  } arp_rsp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REQ,
    ST_WAIT,
    ST_RSP
  } arp_state_e;

  function automatic arp_rsp_t arp_hit_rsp(input logic [MAC_ADDR_BITS-1:0] mac);
    arp_rsp_t r;
    r.rsvd = '0;
    r.hit  = 1'b1;
    r.mac  = mac;
    return r;
  endfunction

endpackage

// File: rtl/arp_cache_cam.sv
// Fully-associative IP->MAC entry array with a combinational match port
// and a single write port; flush clears every valid bit.
module arp_cache_cam
  import arp_lookup_cache_pkg::*;
#(
  parameter int N_ENTRIES = 8,
  parameter int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ARP_LUP_REQ_BITS-1:0] lkp_ip,
  output logic                        lkp_hit,
  output logic [IDX_W-1:0]            lkp_idx,
  output logic [MAC_ADDR_BITS-1:0]    lkp_mac,
  input  logic                        wr_en,
  input  logic [IDX_W-1:0]            wr_idx,
  input  logic [ARP_LUP_REQ_BITS-1:0] wr_ip,
  input  logic [MAC_ADDR_BITS-1:0]    wr_mac,
  input  logic                        flush
);

  logic [N_ENTRIES-1:0]        valid_q;
  logic [N_ENTRIES-1:0]        valid_d;
  logic [ARP_LUP_REQ_BITS-1:0] ip_q  [N_ENTRIES];
  logic [MAC_ADDR_BITS-1:0]    mac_q [N_ENTRIES];

  // Lowest matching index wins; duplicates cannot arise because installs
  // overwrite an existing entry for the same IP.
  always_comb begin
    lkp_hit = 1'b0;
    lkp_idx = '0;
    lkp_mac = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (!lkp_hit && valid_q[i] && (ip_q[i] == lkp_ip)) begin
        lkp_hit = 1'b1;
        lkp_idx = IDX_W'(i);
        lkp_mac = mac_q[i];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      ip_q[wr_idx]  <= wr_ip;
      mac_q[wr_idx] <= wr_mac;
    end
  end

endmodule

// File: rtl/arp_lookup_cache.sv
// ARP resolution cache: local hits, single outstanding network lookup with
// timeout/retry, install of positive replies, and hit/miss/timeout counters.
module arp_lookup_cache
  import arp_lookup_cache_pkg::*;
#(
  parameter int N_ENTRIES      = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 2
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        s_arp_lookup_request_u_valid,
  output logic                        s_arp_lookup_request_u_ready,
  input  logic [ARP_LUP_REQ_BITS-1:0] s_arp_lookup_request_u_data,
  output logic                        m_arp_lookup_reply_u_valid,
  input  logic                        m_arp_lookup_reply_u_ready,
  output logic [ARP_LUP_RSP_BITS-1:0] m_arp_lookup_reply_u_data,
  output logic                        m_arp_lookup_request_n_valid,
  input  logic                        m_arp_lookup_request_n_ready,
  output logic [ARP_LUP_REQ_BITS-1:0] m_arp_lookup_request_n_data,
  input  logic                        s_arp_lookup_reply_n_valid,
  output logic                        s_arp_lookup_reply_n_ready,
  input  logic [ARP_LUP_RSP_BITS-1:0] s_arp_lookup_reply_n_data,
  input  logic                        s_flush,
  output logic [31:0]                 m_hit_cnt,
  output logic [31:0]                 m_miss_cnt,
  output logic [31:0]                 m_timeout_cnt
);

  localparam int IDX_W   = $clog2(N_ENTRIES);
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);
  localparam logic [TMO_W-1:0]   TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  arp_state_e                  state_q, state_d;
  logic [ARP_LUP_REQ_BITS-1:0] ip_q, ip_d;
  logic [RETRY_W-1:0]          retry_q, retry_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  arp_rsp_t                    rsp_q, rsp_d;
  logic [IDX_W-1:0]            ptr_q, ptr_d;
  logic [31:0]                 hit_cnt_q, hit_cnt_d;
  logic [31:0]                 miss_cnt_q, miss_cnt_d;
  logic [31:0]                 to_cnt_q, to_cnt_d;
  logic                        usr_req_rdy_q, usr_req_rdy_d;
  logic                        usr_rsp_vld_q, usr_rsp_vld_d;
  logic                        net_req_vld_q, net_req_vld_d;

  logic                        usr_req_hs, usr_rsp_hs, net_req_hs, net_rsp_hs;
  logic                        net_rsp_hit;
  arp_rsp_t                    net_rsp;
  logic                        cam_hit;
  logic [IDX_W-1:0]            cam_idx;
  logic [MAC_ADDR_BITS-1:0]    cam_mac;
  logic                        wr_en;
  logic [IDX_W-1:0]            wr_idx;

  assign net_rsp     = arp_rsp_t'(s_arp_lookup_reply_n_data);
  assign net_rsp_hit = s_arp_lookup_reply_n_data[ARP_RSP_HIT_BIT];

  assign usr_req_hs = s_arp_lookup_request_u_valid && usr_req_rdy_q;
  assign usr_rsp_hs = usr_rsp_vld_q && m_arp_lookup_reply_u_ready;
  assign net_req_hs = net_req_vld_q && m_arp_lookup_request_n_ready;
  assign net_rsp_hs = s_arp_lookup_reply_n_valid && s_arp_lookup_reply_n_ready;

  arp_cache_cam #(
    .N_ENTRIES (N_ENTRIES),
    .IDX_W     (IDX_W)
  ) u_cam (
    .clk     (aclk),
    .rst_n   (aresetn),
    .lkp_ip  (ip_q),
    .lkp_hit (cam_hit),
    .lkp_idx (cam_idx),
    .lkp_mac (cam_mac),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_ip   (ip_q),
    .wr_mac  (net_rsp.mac),
    .flush   (s_flush)
  );

  always_comb begin
    state_d    = state_q;
    ip_d       = ip_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    rsp_d      = rsp_q;
    ptr_d      = ptr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    to_cnt_d   = to_cnt_q;
    wr_en      = 1'b0;
    wr_idx     = ptr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (usr_req_hs) begin
          ip_d    = s_arp_lookup_request_u_data;
          retry_d = '0;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (cam_hit) begin
          rsp_d     = arp_hit_rsp(cam_mac);
          hit_cnt_d = hit_cnt_q + 32'd1;
          state_d   = ST_RSP;
        end else begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (net_req_hs) begin
          tmo_d   = TMO_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A reply arriving in the expiry cycle takes priority over the timeout.
        if (net_rsp_hs) begin
          rsp_d   = net_rsp;
          state_d = ST_RSP;
          if (net_rsp_hit) begin
            wr_en = 1'b1;
            if (cam_hit) begin
              wr_idx = cam_idx;
            end else begin
              ptr_d = ptr_q + IDX_W'(1);
            end
          end
        end else if (tmo_q == '0) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_REQ;
          end else begin
            rsp_d    = '0;
            to_cnt_d = to_cnt_q + 32'd1;
            state_d  = ST_RSP;
          end
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end
      ST_RSP: begin
        if (usr_rsp_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides any install in the same cycle; the reply still goes out.
    if (s_flush) begin
      wr_en = 1'b0;
      ptr_d = '0;
    end

    usr_req_rdy_d = (state_d == ST_IDLE);
    usr_rsp_vld_d = (state_d == ST_RSP);
    net_req_vld_d = (state_d == ST_REQ);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      ip_q          <= '0;
      retry_q       <= '0;
      tmo_q         <= '0;
      rsp_q         <= '0;
      ptr_q         <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      to_cnt_q      <= '0;
      usr_req_rdy_q <= 1'b1;
      usr_rsp_vld_q <= 1'b0;
      net_req_vld_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ip_q          <= ip_d;
      retry_q       <= retry_d;
      tmo_q         <= tmo_d;
      rsp_q         <= rsp_d;
      ptr_q         <= ptr_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      to_cnt_q      <= to_cnt_d;
      usr_req_rdy_q <= usr_req_rdy_d;
      usr_rsp_vld_q <= usr_rsp_vld_d;
      net_req_vld_q <= net_req_vld_d;
    end
  end

  assign s_arp_lookup_request_u_ready = usr_req_rdy_q;
  assign m_arp_lookup_reply_u_valid   = usr_rsp_vld_q;
  assign m_arp_lookup_reply_u_data    = rsp_q;
  assign m_arp_lookup_request_n_valid = net_req_vld_q;
  assign m_arp_lookup_request_n_data  = ip_q;
  assign s_arp_lookup_reply_n_ready   = 1'b1;
  assign m_hit_cnt                    = hit_cnt_q;
  assign m_miss_cnt                   = miss_cnt_q;
  assign m_timeout_cnt                = to_cnt_q;

endmodule

// File: doc/arp_lookup_cache.md
# arp_lookup_cache

Small fully-associative ARP resolution cache between user logic and the network slice array on the ARP lookup path. A hit returns the MAC locally. A miss issues one request towards the network stack, waits for the reply with a timeout and retry limit, installs positive replies and returns the result. Only one lookup is in flight at a time.

## Interface
- N_ENTRIES, 8: cache entries; power of two, 2..32.
- TIMEOUT_CYCLES, 1024: cycles in WAIT before a retry; ≥ 4.
- MAX_RETRY, 2: re-issues after the first timeout before giving up.
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_arp_lookup_request_u  metaIntf.s  ARP_LUP_REQ_BITS (32)  IPv4 address from user.
- m_arp_lookup_reply_u  metaIntf.m  ARP_LUP_RSP_BITS (56)  reply to user: [47:0] MAC, [48] hit, [55:49] zero.
- m_arp_lookup_request_n  metaIntf.m  32  request towards the slice array and network.
- s_arp_lookup_reply_n  metaIntf.s  56  reply from the network, same format.
- s_flush  in  1  single-cycle pulse; invalidates all entries.
- m_hit_cnt, m_miss_cnt, m_timeout_cnt  out  32 each  wrapping event counters.

## Operation
- FSM states: IDLE, LOOKUP, REQ, WAIT, RSP.
- IDLE:
  - s_arp_lookup_request_u.ready=1.
  - On handshake: latch the IP, clear the retry count, go to LOOKUP.
- LOOKUP:
  - Compare the latched IP against all valid entries.
  - Hit: reply = {7'b0, 1'b1, MAC}, m_hit_cnt++, go to RSP.
  - Miss: m_miss_cnt++, go to REQ.
- REQ:
  - m_arp_lookup_request_n.valid=1 with the latched IP; hold until ready.
  - On handshake: load the timeout counter with TIMEOUT_CYCLES-1, go to WAIT.
- WAIT:
  - s_arp_lookup_reply_n.ready=1. The counter decrements every cycle.
  - Reply handshake: forward the reply unchanged to RSP.
    - If reply hit=1, install {IP, MAC} at the round-robin pointer and advance the pointer modulo N_ENTRIES.
    - If an entry with the same IP already exists, overwrite that entry instead and leave the pointer unchanged.
    - Negative replies are never cached.
  - Counter reaches 0 with no reply:
    - If retries < MAX_RETRY: retries++, back to REQ.
    - Otherwise: reply = 56'h0, m_timeout_cnt++, go to RSP.
  - A reply and the counter expiring in the same cycle: the reply wins.
- RSP:
  - m_arp_lookup_reply_u.valid=1 and data stable until ready.
  - On handshake go to IDLE.
- Outside WAIT: s_arp_lookup_reply_n.ready=1. Replies are discarded with no install and no counter change (stale replies from timed-out attempts).
- s_flush:
  - Clears all valid bits and resets the pointer to 0 in any state. The FSM is unaffected.
  - Flush in the same cycle as an install: flush wins and nothing is installed. The reply is still forwarded.
- Counters wrap 2^32-1 → 0.

## Timing
- Reset values: all valids 0; all outputs valid=0; data 0; counters 0; pointer 0; FSM in IDLE.
- Reset is asynchronous and may abort any state. No request or reply is completed after reset.
- Hit latency: request handshake at cycle t → LOOKUP at t+1 → m_arp_lookup_reply_u.valid at t+2.
- Miss: m_arp_lookup_request_n.valid at t+2. User reply valid one cycle after the network reply handshake.
- Timeout: a retry request is asserted TIMEOUT_CYCLES+1 cycles after the previous request handshake.
- All outputs are registered. No combinational path from any ready to any valid.
- The next user request is accepted no earlier than the cycle after the user reply handshake.

## Structure
- In lynxTypes:
  - arp_rsp_t: packed struct {7'b0, hit, mac[47:0]}.
  - Constants ARP_RSP_HIT_BIT=48 and MAC_ADDR_BITS.
- Sub-module arp_cache_cam:
  - Holds the entry array.
  - Combinational match on an IP gives hit, index and MAC.
  - Write port for install and flush.
- The top level holds the FSM, timeout/retry counters and event counters.

## Test plan
- Cold miss:
  - Request IP 0x0A00000B; network replies {hit=1, MAC 0x001122334455} 5 cycles later.
  - User receives 56'h01_001122334455, m_miss_cnt=1.
  - Same IP again → reply at t+2, no network request, m_hit_cnt=1.
- Negative reply:
  - Network returns hit=0 → user gets hit=0 and MAC 0.
  - Repeat request → network request issued again; nothing cached.
- Timeout with TIMEOUT_CYCLES=16, MAX_RETRY=2, network silent:
  - Exactly 3 requests, each 17 cycles after the previous handshake.
  - User gets 56'h0, m_timeout_cnt=1.
  - A late reply in IDLE is dropped, and the next request for the same IP misses.
- Replacement with N_ENTRIES=8:
  - Install 9 distinct IPs, then look up the first → miss (it was evicted).
  - Look up the 9th → hit.
- Flush:
  - Pulse s_flush in the same cycle as a positive reply in WAIT.
  - The reply is forwarded to the user, and a subsequent lookup of that IP misses.
- Backpressure and reset:
  - Hold m_arp_lookup_reply_u.ready=0 for 10 cycles → data stable, upstream request ready=0.
  - Assert aresetn low mid-WAIT → all valids and counters 0 immediately; FSM in IDLE.
